// File: rtl/mem_stage_lsu.sv
// Memory stage load/store unit: issues one data-memory access at a time, stalls the
// pipeline until it completes, then registers the instruction into MEM/WB.
// Optional MISALIGN_CHECK_EN adds a MisalignM output and blocks unaligned accesses.
module mem_stage_lsu #(
    parameter int DATA_WIDTH             = 32,
    parameter int REG_FILE_ADDRESS_WIDTH = 5
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic                              RegWriteM,
    input  logic [1:0]                        ResultSrcM,
    input  logic                              MemWriteM,
    input  logic [DATA_WIDTH-1:0]             ALUResultM,
    input  logic [DATA_WIDTH-1:0]             WriteDataM,
    input  logic [REG_FILE_ADDRESS_WIDTH-1:0] RdM,
    input  logic [DATA_WIDTH-1:0]             PCPlus4M,
    output logic                              StallM,
    output logic                              mem_req_valid,
    input  logic                              mem_req_ready,
    output logic                              mem_req_we,
    output logic [DATA_WIDTH-1:0]             mem_req_addr,
    output logic [DATA_WIDTH-1:0]             mem_req_wdata,
    input  logic                              mem_rsp_valid,
    input  logic [DATA_WIDTH-1:0]             mem_rsp_rdata,
`ifdef MISALIGN_CHECK_EN
    output logic                              MisalignM,
`endif
    output logic                              RegWriteW,
    output logic [1:0]                        ResultSrcW,
    output logic [DATA_WIDTH-1:0]             ALUResultW,
    output logic [DATA_WIDTH-1:0]             ReadDataW,
    output logic [REG_FILE_ADDRESS_WIDTH-1:0] RdW,
    output logic [DATA_WIDTH-1:0]             PCPlus4W
);

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        REQ  = 2'b01,
        RSP  = 2'b10
    } state_t;

    state_t state_r;
    state_t state_nxt_s;
    logic   access_s;
    logic   is_load_s;
    logic   misalign_s;
    logic   req_valid_s;
    logic   stall_s;

    assign access_s  = MemWriteM | (ResultSrcM == 2'b01);
    assign is_load_s = (ResultSrcM == 2'b01) & ~MemWriteM;

`ifdef MISALIGN_CHECK_EN
    assign misalign_s = access_s & (ALUResultM[1:0] != 2'b00);
    assign MisalignM  = rst_n & misalign_s & (state_r == IDLE);
`else
    assign misalign_s = 1'b0;
`endif

    // Handshake outputs are forced low while reset is held
    assign mem_req_valid = rst_n & req_valid_s;
    assign StallM        = rst_n & stall_s;
    assign mem_req_we    = MemWriteM;
    assign mem_req_addr  = ALUResultM;
    assign mem_req_wdata = WriteDataM;

    // Next-state, request-valid and stall decode
    always_comb begin
        state_nxt_s = state_r;
        req_valid_s = 1'b0;
        stall_s     = 1'b0;
        case (state_r)
            IDLE: begin
                if (access_s && !misalign_s) begin
                    req_valid_s = 1'b1;
                    if (mem_req_ready) begin
                        if (is_load_s) begin
                            stall_s     = 1'b1;
                            state_nxt_s = RSP;
                        end else begin
                            stall_s     = 1'b0;
                        end
                    end else begin
                        stall_s     = 1'b1;
                        state_nxt_s = REQ;
                    end
                end else begin
                    stall_s = 1'b0;
                end
            end
            REQ: begin
                req_valid_s = 1'b1;
                if (mem_req_ready) begin
                    if (is_load_s) begin
                        stall_s     = 1'b1;
                        state_nxt_s = RSP;
                    end else begin
                        stall_s     = 1'b0;
                        state_nxt_s = IDLE;
                    end
                end else begin
                    stall_s = 1'b1;
                end
            end
            RSP: begin
                // Load data arrives here; no new request is issued until it does
                stall_s = ~mem_rsp_valid;
                if (mem_rsp_valid) begin
                    state_nxt_s = IDLE;
                end else begin
                    state_nxt_s = RSP;
                end
            end
            default: begin
                state_nxt_s = IDLE;
            end
        endcase
    end

    // FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // MEM/WB register: load on retire, insert a writeback bubble on stall
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            RegWriteW  <= 1'b0;
            ResultSrcW <= 2'b00;
            ALUResultW <= '0;
            ReadDataW  <= '0;
            RdW        <= '0;
            PCPlus4W   <= '0;
        end else if (!stall_s) begin
            RegWriteW  <= RegWriteM & ~misalign_s;
            ResultSrcW <= ResultSrcM;
            ALUResultW <= ALUResultM;
            RdW        <= RdM;
            PCPlus4W   <= PCPlus4M;
            if (is_load_s && !misalign_s) begin
                ReadDataW <= mem_rsp_rdata;
            end else begin
                ReadDataW <= ReadDataW;
            end
        end else begin
            RegWriteW <= 1'b0;
        end
    end

endmodule

// File: tb/tb_mem_stage_lsu.sv
// Directed self-checking bench for mem_stage_lsu with hand-computed expectations.
module tb_mem_stage_lsu;

    logic        clk;
    logic        rst_n;
    logic        RegWriteM;
    logic [1:0]  ResultSrcM;
    logic        MemWriteM;
    logic [31:0] ALUResultM;
    logic [31:0] WriteDataM;
    logic [4:0]  RdM;
    logic [31:0] PCPlus4M;
    logic        StallM;
    logic        mem_req_valid;
    logic        mem_req_ready;
    logic        mem_req_we;
    logic [31:0] mem_req_addr;
    logic [31:0] mem_req_wdata;
    logic        mem_rsp_valid;
    logic [31:0] mem_rsp_rdata;
`ifdef MISALIGN_CHECK_EN
    logic        MisalignM;
`endif
    logic        RegWriteW;
    logic [1:0]  ResultSrcW;
    logic [31:0] ALUResultW;
    logic [31:0] ReadDataW;
    logic [4:0]  RdW;
    logic [31:0] PCPlus4W;

    int n_checks = 0;
    int n_errors = 0;
    int n_reqs   = 0;

    mem_stage_lsu #(.DATA_WIDTH(32), .REG_FILE_ADDRESS_WIDTH(5)) dut (
        .clk(clk), .rst_n(rst_n),
        .RegWriteM(RegWriteM), .ResultSrcM(ResultSrcM), .MemWriteM(MemWriteM),
        .ALUResultM(ALUResultM), .WriteDataM(WriteDataM), .RdM(RdM), .PCPlus4M(PCPlus4M),
        .StallM(StallM),
        .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_req_we(mem_req_we),
        .mem_req_addr(mem_req_addr), .mem_req_wdata(mem_req_wdata),
        .mem_rsp_valid(mem_rsp_valid), .mem_rsp_rdata(mem_rsp_rdata),
`ifdef MISALIGN_CHECK_EN
        .MisalignM(MisalignM),
`endif
        .RegWriteW(RegWriteW), .ResultSrcW(ResultSrcW), .ALUResultW(ALUResultW),
        .ReadDataW(ReadDataW), .RdW(RdW), .PCPlus4W(PCPlus4W)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Count accepted requests for the back-to-back test
    always @(posedge clk) begin
        if (mem_req_valid && mem_req_ready) n_reqs <= n_reqs + 1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_m(input logic rw, input logic [1:0] rs, input logic mw,
                         input logic [31:0] alu, input logic [31:0] wd,
                         input logic [4:0] rd, input logic [31:0] pc4);
        RegWriteM = rw; ResultSrcM = rs; MemWriteM = mw;
        ALUResultM = alu; WriteDataM = wd; RdM = rd; PCPlus4M = pc4;
    endtask

    int base_reqs;

    initial begin
        rst_n = 1'b0;
        mem_req_ready = 1'b0; mem_rsp_valid = 1'b0; mem_rsp_rdata = 32'h0;
        set_m(1'b1, 2'b00, 1'b1, 32'h100, 32'h1, 5'd1, 32'h4);
        #2;
        check("rst_valid", {31'h0, mem_req_valid}, 32'h0);
        check("rst_stall", {31'h0, StallM}, 32'h0);
        tick(); tick();
        check("rst_regwrite", {31'h0, RegWriteW}, 32'h0);
        check("rst_alu", ALUResultW, 32'h0);
        check("rst_rd", {27'h0, RdW}, 32'h0);
        check("rst_pc4", PCPlus4W, 32'h0);
        rst_n = 1'b1;

        // ALU op retires in one cycle
        set_m(1'b1, 2'b00, 1'b0, 32'h1234, 32'h0, 5'd5, 32'h8);
        #1;
        check("alu_stall", {31'h0, StallM}, 32'h0);
        check("alu_valid", {31'h0, mem_req_valid}, 32'h0);
        tick();
        check("alu_regwrite", {31'h0, RegWriteW}, 32'h1);
        check("alu_rd", {27'h0, RdW}, 32'd5);
        check("alu_result", ALUResultW, 32'h1234);
        check("alu_pc4", PCPlus4W, 32'h8);

        // Store with ready low for 3 cycles
        set_m(1'b0, 2'b00, 1'b1, 32'h100, 32'hDEADBEEF, 5'd0, 32'hC);
        for (int i = 0; i < 4; i++) begin
            mem_req_ready = (i == 3);
            #1;
            check("st_valid", {31'h0, mem_req_valid}, 32'h1);
            check("st_we", {31'h0, mem_req_we}, 32'h1);
            check("st_addr", mem_req_addr, 32'h100);
            check("st_wdata", mem_req_wdata, 32'hDEADBEEF);
            check("st_stall", {31'h0, StallM}, (i < 3) ? 32'h1 : 32'h0);
            tick();
            if (i < 3) begin
                check("st_bubble", {31'h0, RegWriteW}, 32'h0);
                check("st_hold_alu", ALUResultW, 32'h1234);
            end
        end
        check("st_retire_alu", ALUResultW, 32'h100);
        check("st_retire_pc4", PCPlus4W, 32'hC);

        // Load, accepted immediately, response two cycles later
        set_m(1'b1, 2'b01, 1'b0, 32'h40, 32'h0, 5'd7, 32'h10);
        mem_req_ready = 1'b1;
        #1;
        check("ld_valid", {31'h0, mem_req_valid}, 32'h1);
        check("ld_we", {31'h0, mem_req_we}, 32'h0);
        check("ld_stall0", {31'h0, StallM}, 32'h1);
        tick();
        mem_req_ready = 1'b0;
        #1;
        check("ld_rsp_valid_low", {31'h0, mem_req_valid}, 32'h0);
        check("ld_stall1", {31'h0, StallM}, 32'h1);
        tick();
        check("ld_bubble", {31'h0, RegWriteW}, 32'h0);
        check("ld_hold_rd", {27'h0, RdW}, 32'd0);
        mem_rsp_valid = 1'b1; mem_rsp_rdata = 32'hCAFEF00D;
        #1;
        check("ld_stall2", {31'h0, StallM}, 32'h0);
        tick();
        mem_rsp_valid = 1'b0;
        check("ld_data", ReadDataW, 32'hCAFEF00D);
        check("ld_rd", {27'h0, RdW}, 32'd7);
        check("ld_regwrite", {31'h0, RegWriteW}, 32'h1);
        check("ld_ressrc", {30'h0, ResultSrcW}, 32'h1);

        // Back-to-back load then store
        base_reqs = n_reqs;
        set_m(1'b1, 2'b01, 1'b0, 32'h80, 32'h0, 5'd9, 32'h14);
        mem_req_ready = 1'b1;
        #1;
        check("bb_ld_we", {31'h0, mem_req_we}, 32'h0);
        check("bb_ld_valid", {31'h0, mem_req_valid}, 32'h1);
        tick();
        mem_rsp_valid = 1'b1; mem_rsp_rdata = 32'h11112222;
        #1;
        check("bb_rsp_no_req", {31'h0, mem_req_valid}, 32'h0);
        check("bb_rsp_stall", {31'h0, StallM}, 32'h0);
        tick();
        mem_rsp_valid = 1'b0;
        check("bb_ld_data", ReadDataW, 32'h11112222);
        check("bb_ld_rd", {27'h0, RdW}, 32'd9);
        set_m(1'b0, 2'b00, 1'b1, 32'h84, 32'h55AA55AA, 5'd0, 32'h18);
        #1;
        check("bb_st_we", {31'h0, mem_req_we}, 32'h1);
        check("bb_st_valid", {31'h0, mem_req_valid}, 32'h1);
        check("bb_st_stall", {31'h0, StallM}, 32'h0);
        tick();
        mem_req_ready = 1'b0;
        set_m(1'b0, 2'b00, 1'b0, 32'h0, 32'h0, 5'd0, 32'h1C);
        check("bb_st_alu", ALUResultW, 32'h84);
        check("bb_st_rdata_hold", ReadDataW, 32'h11112222);
        check("bb_req_count", n_reqs - base_reqs, 32'd2);

        // Reset while waiting for a load response
        set_m(1'b1, 2'b01, 1'b0, 32'h44, 32'h0, 5'd3, 32'h20);
        mem_req_ready = 1'b1;
        tick();
        mem_req_ready = 1'b0;
        #1;
        check("rr_in_rsp", {31'h0, StallM}, 32'h1);
        rst_n = 1'b0;
        #1;
        check("rr_stall", {31'h0, StallM}, 32'h0);
        check("rr_valid", {31'h0, mem_req_valid}, 32'h0);
        check("rr_regwrite", {31'h0, RegWriteW}, 32'h0);
        check("rr_alu", ALUResultW, 32'h0);
        check("rr_rdata", ReadDataW, 32'h0);
        check("rr_rd", {27'h0, RdW}, 32'd0);
        check("rr_pc4", PCPlus4W, 32'h0);
        tick();
        rst_n = 1'b1;
        set_m(1'b0, 2'b00, 1'b0, 32'h55, 32'h0, 5'd2, 32'h24);
        mem_rsp_valid = 1'b1; mem_rsp_rdata = 32'h00000BAD;
        #1;
        check("rr_idle_stall", {31'h0, StallM}, 32'h0);
        tick();
        mem_rsp_valid = 1'b0;
        check("rr_ignore_rsp", ReadDataW, 32'h0);
        check("rr_retire_alu", ALUResultW, 32'h55);

`ifdef MISALIGN_CHECK_EN
        // Misaligned load is blocked and retires as a bubble
        set_m(1'b1, 2'b01, 1'b0, 32'h102, 32'h0, 5'd4, 32'h28);
        mem_req_ready = 1'b1;
        #1;
        check("mis_flag", {31'h0, MisalignM}, 32'h1);
        check("mis_valid", {31'h0, mem_req_valid}, 32'h0);
        check("mis_stall", {31'h0, StallM}, 32'h0);
        tick();
        mem_req_ready = 1'b0;
        check("mis_regwrite", {31'h0, RegWriteW}, 32'h0);
        check("mis_alu", ALUResultW, 32'h102);
        check("mis_rdata_hold", ReadDataW, 32'h0);
`endif

        tick();
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
